// File: rtl/mux_rd_arbiter.sv
// mux_rd_arbiter
//   Round-robin arbiter and sequencer that shares one 2**address-entry read
//   mux between NREQ requesters. Each cycle it grants one requester, drives
//   the mux select with that requester's address, and captures the mux
//   output in a response register that has valid/ready backpressure.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      synchronous active-low reset
//   req_i       per-requester read request level
//   addr_i      per-requester read address
//   gnt_o       one-hot combinational grant
//   sel_o       select to the shared mux
//   mux_data_i  combinational output of the shared mux
//   rvalid_o    response valid
//   rready_i    response consumer ready
//   rid_o       index of the requester that owns rdata_o
//   rdata_o     registered read data
//   burst_i     (MUXARB_BURST_EN only) beats-1 per requester
//   rlast_o     (MUXARB_BURST_EN only) last beat of a response sequence
//
// Optional feature: define MUXARB_BURST_EN to add incrementing bursts of
// up to four beats per grant.
module mux_rd_arbiter #(
  parameter int n       = 4,
  parameter int address = 8,
  parameter int NREQ    = 4,
  parameter int IDW     = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NREQ-1:0]                  req_i,
  input  logic [NREQ-1:0][address-1:0]     addr_i,
`ifdef MUXARB_BURST_EN
  input  logic [NREQ-1:0][1:0]             burst_i,
  output logic                             rlast_o,
`endif
  output logic [NREQ-1:0]                  gnt_o,
  output logic [address-1:0]               sel_o,
  input  logic [n-1:0]                     mux_data_i,
  output logic                             rvalid_o,
  input  logic                             rready_i,
  output logic [IDW-1:0]                   rid_o,
  output logic [n-1:0]                     rdata_o
);

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] w);
    return IDW'((int'(w) + 1) % NREQ);
  endfunction

  logic [IDW-1:0]     ptr;
  logic [address-1:0] sel_q;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     cand;
  logic               found;
  logic               stall;
  logic               grant;
  logic               in_burst;

  assign stall = rvalid_o & ~rready_i;

`ifdef MUXARB_BURST_EN
  typedef enum logic {IDLE, BURST} state_t;
  state_t             state;
  logic [address-1:0] base;
  logic [1:0]         cnt;
  logic [1:0]         k;
  logic [IDW-1:0]     owner;
  logic               burst_beat;

  assign in_burst   = (state == BURST);
  assign burst_beat = in_burst & ~stall & rst_ni;
`else
  assign in_burst = 1'b0;
`endif

  // Rotating priority search starting at ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = IDW'((int'(ptr) + j) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // No arbitration while stalled, in reset, or while a burst owns the mux.
  assign grant = found & ~stall & rst_ni & ~in_burst;
  assign gnt_o = grant ? (NREQ'(1) << win) : '0;

  always_comb begin
    sel_o = sel_q;
`ifdef MUXARB_BURST_EN
    if (in_burst) sel_o = base + {{(address-2){1'b0}}, k};
    else
`endif
    if (grant) sel_o = addr_i[win];
  end

  // Stage p0 -> response register: control, read data and last select.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      rid_o    <= '0;
      ptr      <= '0;
      sel_q    <= '0;
`ifdef MUXARB_BURST_EN
      state    <= IDLE;
      rlast_o  <= 1'b0;
`endif
    end else if (!stall) begin
      // Not stalled means any pending response is consumed this edge, so
      // valid simply follows whether a new beat is loaded.
      rvalid_o <= grant | in_burst;
      if (grant) begin
        rdata_o <= mux_data_i;
        rid_o   <= win;
        sel_q   <= addr_i[win];
        ptr     <= next_ptr(win);
`ifdef MUXARB_BURST_EN
        if (burst_i[win] != 2'd0) begin
          state   <= BURST;
          rlast_o <= 1'b0;
        end else begin
          rlast_o <= 1'b1;
        end
      end else if (in_burst) begin
        rdata_o <= mux_data_i;
        rid_o   <= owner;
        sel_q   <= sel_o;
        if (k == cnt) begin
          rlast_o <= 1'b1;
          state   <= IDLE;
          ptr     <= next_ptr(owner);
        end else begin
          rlast_o <= 1'b0;
        end
`endif
      end
    end
  end

`ifdef MUXARB_BURST_EN
  // Burst context; only meaningful while state is BURST, so left unreset.
  always_ff @(posedge clk_i) begin
    if (grant && burst_i[win] != 2'd0) begin
      base  <= addr_i[win];
      cnt   <= burst_i[win];
      owner <= win;
      k     <= 2'd1;
    end else if (burst_beat && k != cnt) begin
      k <= k + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rd_arbiter.sv
// tb_mux_rd_arbiter
//   Directed-vector bench for mux_rd_arbiter. The shared mux is modelled as
//   data = sel[7:4] ^ sel[3:0] ^ 4'h3, so address 8'h5A reads back 4'hC.
module tb_mux_rd_arbiter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [3:0][7:0] addr;
  logic [3:0]      gnt;
  logic [7:0]      sel;
  logic [3:0]      mux_data;
  logic            rvalid;
  logic            rready;
  logic [1:0]      rid;
  logic [3:0]      rdata;
`ifdef MUXARB_BURST_EN
  logic [3:0][1:0] burst;
  logic            rlast;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mux_data = sel[7:4] ^ sel[3:0] ^ 4'h3;

  mux_rd_arbiter #(.n(4), .address(8), .NREQ(4), .IDW(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .addr_i     (addr),
`ifdef MUXARB_BURST_EN
    .burst_i    (burst),
    .rlast_o    (rlast),
`endif
    .gnt_o      (gnt),
    .sel_o      (sel),
    .mux_data_i (mux_data),
    .rvalid_o   (rvalid),
    .rready_i   (rready),
    .rid_o      (rid),
    .rdata_o    (rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected grant / select / read data for the round-robin sweep.
  logic [3:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_sel  [5] = '{8'h10, 8'h21, 8'h5A, 8'h63, 8'h10};
  logic [1:0] rr_rid  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rr_data [5] = '{4'h2, 4'h0, 4'hC, 4'h6, 4'h2};

  initial begin
    rst_n   = 1'b0;
    req     = 4'b1111;
    rready  = 1'b1;
    addr[0] = 8'h10;
    addr[1] = 8'h21;
    addr[2] = 8'h5A;
    addr[3] = 8'h63;
`ifdef MUXARB_BURST_EN
    burst   = '0;
`endif
    #1;
    check("rst_gnt_early", gnt, 4'b0000);

    // Reset held two cycles with all requesters asking.
    tick();
    check("rst_gnt_1", gnt, 4'b0000);
    tick();
    check("rst_gnt_2", gnt, 4'b0000);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 4'h0);
    check("rst_rid", rid, 2'd0);
    check("rst_sel", sel, 8'h00);

    // Release; round robin with all four requesting.
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("rr_gnt", gnt, rr_gnt[c]);
      check("rr_sel", sel, rr_sel[c]);
      tick();
      check("rr_rvalid", rvalid, 1'b1);
      check("rr_rid", rid, rr_rid[c]);
      check("rr_rdata", rdata, rr_data[c]);
    end

    // No requests: no grant, select holds, response drains.
    req = 4'b0000;
    #1;
    check("idle_gnt", gnt, 4'b0000);
    check("idle_sel", sel, 8'h10);
    tick();
    check("idle_rvalid", rvalid, 1'b0);
    check("idle_rdata", rdata, 4'h2);

    // Single read by requester 2.
    req = 4'b0100;
    #1;
    check("single_gnt", gnt, 4'b0100);
    check("single_sel", sel, 8'h5A);
    tick();
    req = 4'b0000;
    check("single_rvalid", rvalid, 1'b1);
    check("single_rid", rid, 2'd2);
    check("single_rdata", rdata, 4'hC);

    // Backpressure: consumer not ready for three cycles, requester 1 pending.
    rready = 1'b0;
    req    = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_gnt", gnt, 4'b0000);
      tick();
      check("bp_rvalid", rvalid, 1'b1);
      check("bp_rid", rid, 2'd2);
      check("bp_rdata", rdata, 4'hC);
    end
    rready = 1'b1;
    #1;
    check("bp_release_gnt", gnt, 4'b0010);
    check("bp_release_sel", sel, 8'h21);
    tick();
    req = 4'b0000;
    check("bp_after_rid", rid, 2'd1);
    check("bp_after_rdata", rdata, 4'h0);
    check("bp_after_rvalid", rvalid, 1'b1);

    // Move ptr to 3 with a response outstanding, then reset.
    req = 4'b0100;
    #1;
    check("pre_rst_gnt", gnt, 4'b0100);
    tick();
    req   = 4'b0000;
    rst_n = 1'b0;
    tick();
    check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_rdata", rdata, 4'h0);
    check("mid_rst_rid", rid, 2'd0);
    rst_n = 1'b1;
    req   = 4'b1001;
    #1;
    check("post_rst_gnt", gnt, 4'b0001);
    tick();
    req = 4'b0000;
    check("post_rst_rid", rid, 2'd0);
    check("post_rst_rdata", rdata, 4'h2);

    // Requester 3 asks alone repeatedly: granted every unstalled cycle.
    req = 4'b1000;
    #1;
    check("solo_gnt_a", gnt, 4'b1000);
    tick();
    check("solo_rid_a", rid, 2'd3);
    check("solo_gnt_b", gnt, 4'b1000);
    tick();
    req = 4'b0000;
    check("solo_rid_b", rid, 2'd3);
    check("solo_rdata_b", rdata, 4'h6);
    tick();

`ifdef MUXARB_BURST_EN
    // Four-beat burst from requester 3 wrapping through address 0.
    addr[3]  = 8'hFE;
    burst[3] = 2'd3;
    req      = 4'b1000;
    #1;
    check("burst_gnt0", gnt, 4'b1000);
    check("burst_sel0", sel, 8'hFE);
    tick();
    req = 4'b0001;
    check("burst_rdata0", rdata, 4'h2);
    check("burst_rlast0", rlast, 1'b0);
    check("burst_gnt1", gnt, 4'b0000);
    check("burst_sel1", sel, 8'hFF);
    tick();
    check("burst_rid1", rid, 2'd3);
    check("burst_rdata1", rdata, 4'h3);
    check("burst_gnt2", gnt, 4'b0000);
    check("burst_sel2", sel, 8'h00);
    tick();
    check("burst_rdata2", rdata, 4'h3);
    check("burst_sel3", sel, 8'h01);
    check("burst_gnt3", gnt, 4'b0000);
    tick();
    check("burst_rdata3", rdata, 4'h2);
    check("burst_rlast3", rlast, 1'b1);
    check("burst_rid3", rid, 2'd3);
    check("burst_next_gnt", gnt, 4'b0001);
    tick();
    req = 4'b0000;
    check("burst_next_rlast", rlast, 1'b1);
    check("burst_next_rid", rid, 2'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rd_arbiter.md
Name: mux_rd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 256-entry read multiplexer (mux256to1_n-class datapath, 2**address inputs) between NREQ requesters.
- Picks one requester per cycle and drives the mux select with that requester's address.
- Captures the mux output into a response register, with valid/ready backpressure.
- Sits between the request sources (core ports, debug port) and the shared storage read mux.

Parameters:
- n, 4, data width of each mux entry and of rdata_o.
- address, 8, select width; the mux has 2**address entries.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rid_o; must satisfy 2**IDW >= NREQ.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  synchronous active-low reset.
- req_i  in  NREQ  per-requester read request level.
- addr_i  in  NREQ x address  per-requester read address; held stable while req_i is high.
- gnt_o  out  NREQ  one-hot grant, combinational, high for one cycle per accepted request.
- sel_o  out  address  select to the shared mux.
- mux_data_i  in  n  combinational output of the shared mux.
- rvalid_o  out  1  response valid.
- rready_i  in  1  response consumer ready.
- rid_o  out  IDW  index of the requester that owns rdata_o.
- rdata_o  out  n  registered read data.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - rvalid_o=0, rdata_o=0, rid_o=0.
  - Priority pointer ptr=0, FSM state=IDLE.
  - gnt_o=0 while rst_ni=0.
- stall = rvalid_o & ~rready_i. While stall is high, gnt_o=0, no state changes, and rdata_o/rid_o hold.
- Arbitration (when not stalled):
  - Winner w is the first i with req_i[i]=1, searching ptr, ptr+1, ... modulo NREQ.
  - gnt_o[w]=1 in the same cycle; sel_o=addr_i[w].
  - With no requests: gnt_o=0 and sel_o holds its last value (0 after reset).
- Response:
  - On the edge where gnt_o[w]=1: rdata_o<=mux_data_i, rid_o<=w, rvalid_o<=1, ptr<=(w+1) mod NREQ.
  - Latency: grant cycle T, data visible at T+1.
- Response handshake:
  - The response completes on any edge with rvalid_o & rready_i.
  - rvalid_o clears on that edge unless a new grant happens in the same cycle. That is allowed, so throughput is one read per cycle.
- A requester drops req_i the cycle after its gnt_o. If req_i stays high, it is re-arbitrated as a new request.
- req_i deasserted before a grant: no grant, no response. Requests are not buffered.
- Fairness: a continuously requesting source waits at most NREQ-1 grants.
- ptr moves only on a grant. A single active requester is granted every unstalled cycle.
- Reset asserted mid-burst or with rvalid_o=1: the response and burst are discarded, and the reset values apply at that edge.

Optional Feature:
- Macro: MUXARB_BURST_EN.
- When defined, these ports are added:
  - burst_i (in, NREQ x 2): beats-1 per requester.
  - rlast_o (out, 1): last beat of a response sequence.
- FSM states IDLE and BURST:
  - IDLE: a grant with burst_i[w]>0 latches base=addr_i[w], cnt=burst_i[w], owner=w, and moves to BURST. gnt_o pulses on that first beat only.
  - BURST: no arbitration; gnt_o=0. sel_o = base + k modulo 2**address, so address 255 wraps to 0. One beat per unstalled cycle, each beat loaded as a response with rid_o=owner.
  - The beat where k reaches cnt sets rlast_o=1 and returns to IDLE. ptr<=owner+1 on that return.
  - Single beats (burst_i=0) have rlast_o=1.
  - Stall freezes k and the FSM.
- When not defined: no burst_i/rlast_o ports, no BURST state, single-beat behaviour only.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles with req_i=4'b1111 -> gnt_o=0, rvalid_o=0, rdata_o=0. First grant after release goes to requester 0.
- Single read: req_i=4'b0100, addr_i[2]=8'h5A, mux model returns 4'hC -> gnt_o=4'b0100 and sel_o=8'h5A at T; rvalid_o=1, rid_o=2, rdata_o=4'hC at T+1.
- Round robin: req_i=4'b1111 held, rready_i=1 -> grant order 0,1,2,3,0 on consecutive cycles, with rid_o following one cycle later.
- Backpressure: rready_i=0 for 3 cycles with rvalid_o=1 and req_i=4'b0010 pending -> gnt_o=0 and rdata_o stable. Grant to requester 1 occurs in the cycle rready_i returns to 1.
- Reset mid-operation: rst_ni=0 while rvalid_o=1 and ptr=3 -> next cycle rvalid_o=0. After release, req_i=4'b1001 is granted to 0, not 3.
- MUXARB_BURST_EN: requester 3, addr 8'hFE, burst_i=2'd3 -> sel_o=FE,FF,00,01 on 4 cycles, gnt_o[3] only on the first. rlast_o=1 on the beat for 8'h01. Other requests are ignored until then.
